// File: rtl/dmem_slave.sv
// dmem_slave: single-port word memory behind a simple valid/ready read/write
// slave. One request is in flight at a time, reads win over writes, and the
// response appears a fixed number of clocks after the accepting edge.
// Optional feature: define DMEM_RAND_DELAY_EN to add pseudo-random extra wait
// cycles (LFSR driven) on top of LATENCY.
module dmem_slave #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [7:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready
);

    localparam int         WORDS  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  cnt, cnt_nxt, cnt_load;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        accept_rd, accept_wr, rd_done, wr_done;
    logic [31:0] offset;
    logic        addr_ok;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic        unused_bits;

    logic [31:0] mem [WORDS];

    assign accept_rd = (state == IDLE) && i_arvalid;
    assign accept_wr = (state == IDLE) && !i_arvalid && i_awvalid && i_wvalid;
    assign rd_done   = (state == RD_WAIT) && (cnt == 4'd0);
    assign wr_done   = (state == WR_WAIT) && (cnt == 4'd0);

    // Address decode works on the latched address; the subtraction cannot wrap
    // once addr_q >= BASE_ADDR, so the top-bits test is a clean range check.
    assign offset   = addr_q - BASE_ADDR;
    assign addr_ok  = (addr_q >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign word_idx = offset[DEPTH_LOG2+1:2];

    // Upper strobe bits and the byte offset within a word carry no meaning here.
    assign unused_bits = ^{i_wstrb[7:4], offset[1:0]};

    assign o_arready = (state == IDLE);
    assign o_awready = accept_wr;
    assign o_wready  = accept_wr;
    assign o_rvalid  = (state == RD_RESP);
    assign o_bvalid  = (state == WR_RESP);

`ifdef DMEM_RAND_DELAY_EN
    logic [3:0] lfsr;
    logic [4:0] load_sum;

    // Step the x^4+x^3+1 LFSR once for every accepted request.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 4'b1001;
        else if (accept_rd || accept_wr)
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    // Extra delay can push the total past what the 4-bit counter holds, so
    // the load value saturates at the counter's maximum.
    assign load_sum = {1'b0, LAT_M1} + {2'b00, lfsr[2:0]};
    assign cnt_load = load_sum[4] ? 4'hF : load_sum[3:0];
`else
    assign cnt_load = LAT_M1;
`endif

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in *_WAIT, hold the
    // response until the initiator takes it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_rd) begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = cnt_load;
                end else if (accept_wr) begin
                    state_nxt = WR_WAIT;
                    cnt_nxt   = cnt_load;
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = RD_RESP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            RD_RESP: begin
                if (i_rready)
                    state_nxt = IDLE;
            end
            WR_WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = WR_RESP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            WR_RESP: begin
                if (i_bready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request fields on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (accept_rd) begin
            addr_q <= i_araddr;
        end else if (accept_wr) begin
            addr_q  <= i_awaddr;
            wdata_q <= i_wdata;
            wstrb_q <= i_wstrb[3:0];
        end
    end

    // Response registers: loaded when the wait ends, held until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= 32'd0;
            o_rresp <= RESP_OKAY;
            o_bresp <= RESP_OKAY;
        end else begin
            if (rd_done) begin
                o_rdata <= addr_ok ? mem[word_idx] : 32'd0;
                o_rresp <= addr_ok ? RESP_OKAY : RESP_DECERR;
            end
            if (wr_done)
                o_bresp <= addr_ok ? RESP_OKAY : RESP_DECERR;
        end
    end

    // Byte-lane write when the write wait ends; memory itself is never reset
    // and a reset on the same edge cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_done && addr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_q[k])
                    mem[word_idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_slave.sv
// tb_dmem_slave: drives two dmem_slave instances (LATENCY 1 and 4) with
// directed transfers and compares every cycle against a transaction-level
// model of the memory and its response timing.
module tb_dmem_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          NW   = 1024;

    logic        clk;
    logic        rst     [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [7:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;
    int edge_no = 0;

    // Model state: kind 0 = idle, 1 = read pending, 2 = write pending
    int          m_kind  [2];
    int          m_due   [2];
    bit          m_resp  [2];
    logic [31:0] m_rdata [2];
    bit          m_rknown[2];
    logic [1:0]  m_rresp [2];
    logic [1:0]  m_bresp [2];
    bit          m_winr  [2];
    int          m_widx  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic [3:0]  m_lfsr  [2];
    logic [31:0] mdl_mem   [2][NW];
    bit          mdl_known [2][NW];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_slave #(
            .DEPTH_LOG2 (10),
            .BASE_ADDR  (32'h8000_0000),
            .LATENCY    ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .i_araddr  (araddr[g]),
            .i_arvalid (arvalid[g]),
            .o_arready (arready[g]),
            .o_rdata   (rdata[g]),
            .o_rresp   (rresp[g]),
            .o_rvalid  (rvalid[g]),
            .i_rready  (rready[g]),
            .i_awaddr  (awaddr[g]),
            .i_awvalid (awvalid[g]),
            .o_awready (awready[g]),
            .i_wdata   (wdata[g]),
            .i_wstrb   (wstrb[g]),
            .i_wvalid  (wvalid[g]),
            .o_wready  (wready[g]),
            .o_bresp   (bresp[g]),
            .o_bvalid  (bvalid[g]),
            .i_bready  (bready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
    endtask

    // Transaction-level model: a request accepted at edge E responds from
    // edge E+latency until the edge that sees ready; writes land at E+latency.
    always @(posedge clk) begin : model
        logic [31:0] off;
        bit          inr;
        int          idx;
        int          wt;
        edge_no++;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                m_kind[k] = 0;
                m_resp[k] = 0;
                m_lfsr[k] = 4'b1001;
            end else if (m_kind[k] == 0) begin
                if (arvalid[k] || (awvalid[k] && wvalid[k])) begin
                    wt = latOf(k);
`ifdef DMEM_RAND_DELAY_EN
                    wt = wt + int'(m_lfsr[k][2:0]);
                    if (wt > 16) wt = 16;
                    m_lfsr[k] = {m_lfsr[k][2:0], m_lfsr[k][3] ^ m_lfsr[k][2]};
`endif
                    m_due[k] = edge_no + wt;
                end
                if (arvalid[k]) begin
                    off = araddr[k] - BASE;
                    inr = (araddr[k] >= BASE) && (off < 32'd4096);
                    idx = inr ? int'(off[11:2]) : 0;
                    m_kind[k]   = 1;
                    m_rresp[k]  = inr ? 2'b00 : 2'b11;
                    m_rdata[k]  = inr ? mdl_mem[k][idx] : 32'd0;
                    m_rknown[k] = inr ? mdl_known[k][idx] : 1'b1;
                end else if (awvalid[k] && wvalid[k]) begin
                    off = awaddr[k] - BASE;
                    inr = (awaddr[k] >= BASE) && (off < 32'd4096);
                    m_kind[k]  = 2;
                    m_winr[k]  = inr;
                    m_widx[k]  = inr ? int'(off[11:2]) : 0;
                    m_wdata[k] = wdata[k];
                    m_wstrb[k] = wstrb[k][3:0];
                    m_bresp[k] = inr ? 2'b00 : 2'b11;
                end
            end else if (!m_resp[k]) begin
                if (edge_no == m_due[k]) begin
                    m_resp[k] = 1;
                    if (m_kind[k] == 2 && m_winr[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[k][b])
                                mdl_mem[k][m_widx[k]][8*b +: 8] = m_wdata[k][8*b +: 8];
                        if (m_wstrb[k] == 4'hF)
                            mdl_known[k][m_widx[k]] = 1;
                    end
                end
            end else if ((m_kind[k] == 1 && rready[k]) || (m_kind[k] == 2 && bready[k])) begin
                m_kind[k] = 0;
                m_resp[k] = 0;
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput("arready", k, 32'(arready[k]), 32'(m_kind[k] == 0));
                checkOutput("awready", k, 32'(awready[k]),
                            32'(m_kind[k] == 0 && awvalid[k] && wvalid[k] && !arvalid[k]));
                checkOutput("wready", k, 32'(wready[k]),
                            32'(m_kind[k] == 0 && awvalid[k] && wvalid[k] && !arvalid[k]));
                checkOutput("rvalid", k, 32'(rvalid[k]), 32'(m_resp[k] && m_kind[k] == 1));
                checkOutput("bvalid", k, 32'(bvalid[k]), 32'(m_resp[k] && m_kind[k] == 2));
                if (m_resp[k] && m_kind[k] == 1) begin
                    if (m_rknown[k])
                        checkOutput("rdata", k, rdata[k], m_rdata[k]);
                    checkOutput("rresp", k, 32'(rresp[k]), 32'(m_rresp[k]));
                end
                if (m_resp[k] && m_kind[k] == 2)
                    checkOutput("bresp", k, 32'(bresp[k]), 32'(m_bresp[k]));
            end
        end
    end

    // Drive a request and wait for the edge that accepts it.
    task automatic applyStimulus(input int k, input bit is_wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [7:0] strb);
        bit acc;
        int n;
        if (is_wr) begin
            awaddr[k] = addr; wdata[k] = data; wstrb[k] = strb;
            awvalid[k] = 1'b1; wvalid[k] = 1'b1;
        end else begin
            araddr[k] = addr; arvalid[k] = 1'b1;
        end
        acc = 0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = is_wr ? (awready[k] && wready[k]) : arready[k];
            @(posedge clk);
            #1;
            n++;
        end
        arvalid[k] = 1'b0; awvalid[k] = 1'b0; wvalid[k] = 1'b0;
        if (!acc) checkOutput("accept_timeout", k, 32'(acc), 32'd1);
    endtask

    // Wait for the response, count edges since accept, hold ready low for
    // 'hold' cycles, then handshake.
    task automatic awaitResponse(input int k, input bit is_wr, input int hold,
                                 output logic [31:0] got_data, output logic [1:0] got_resp,
                                 output int got_lat);
        bit vis;
        int n;
        vis = 0; n = 0;
        got_data = '0; got_resp = '0; got_lat = -1;
        while (!vis && n < 40) begin
            @(negedge clk);
            vis = is_wr ? bvalid[k] : rvalid[k];
            if (!vis) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!vis) begin
            checkOutput("resp_timeout", k, 32'(vis), 32'd1);
            return;
        end
        got_lat  = n;
        got_data = rdata[k];
        got_resp = is_wr ? bresp[k] : rresp[k];
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (is_wr) bready[k] = 1'b1; else rready[k] = 1'b1;
        @(posedge clk);
        #1;
        bready[k] = 1'b0;
        rready[k] = 1'b0;
    endtask

    task automatic doTransfer(input int k, input bit is_wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [7:0] strb, input int hold,
                              output logic [31:0] got_data, output logic [1:0] got_resp,
                              output int got_lat);
        applyStimulus(k, is_wr, addr, data, strb);
        awaitResponse(k, is_wr, hold, got_data, got_resp, got_lat);
    endtask

    initial begin : watchdog
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
            awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0;
            wvalid[k] = 1'b0; bready[k] = 1'b0;
            for (int i = 0; i < NW; i++) mdl_known[k][i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_en = 1;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
            checkOutput("rst_bvalid", k, 32'(bvalid[k]), 32'd0);
            checkOutput("rst_rdata",  k, rdata[k], 32'd0);
            checkOutput("rst_rresp",  k, 32'(rresp[k]), 32'd0);
            checkOutput("rst_bresp",  k, 32'(bresp[k]), 32'd0);
            checkOutput("rst_arready", k, 32'(arready[k]), 32'd1);
        end
        @(posedge clk);
        #1;

        // Full-word write then read back, single-cycle latency
        doTransfer(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, d, r, l);
        checkOutput("wr1_bresp", 0, 32'(r), 32'd0);
`ifndef DMEM_RAND_DELAY_EN
        checkOutput("wr1_lat", 0, 32'(l), 32'd1);
`endif
        doTransfer(0, 0, 32'h8000_0010, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("rd1_data", 0, d, 32'hDEAD_BEEF);
        checkOutput("rd1_rresp", 0, 32'(r), 32'd0);
`ifndef DMEM_RAND_DELAY_EN
        checkOutput("rd1_lat", 0, 32'(l), 32'd1);
`endif

        // Single-lane write at an unaligned address; strobe bits [7:4] ignored
        doTransfer(0, 1, 32'h8000_0012, 32'h0000_AA00, 8'hF2, 0, d, r, l);
        doTransfer(0, 0, 32'h8000_0013, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("rd2_data", 0, d, 32'hDEAD_AAEF);

        // Range boundaries: word 0, last word, just below, just above
        doTransfer(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0F, 0, d, r, l);
        doTransfer(0, 1, 32'h8000_0FFC, 32'h0BAD_C0DE, 8'h0F, 0, d, r, l);
        doTransfer(0, 0, 32'h7FFF_FFFC, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("oor_rd_resp", 0, 32'(r), 32'd3);
        checkOutput("oor_rd_data", 0, d, 32'd0);
        doTransfer(0, 1, 32'h8000_1000, 32'h1234_5678, 8'h0F, 0, d, r, l);
        checkOutput("oor_wr_resp", 0, 32'(r), 32'd3);
        doTransfer(0, 0, 32'h8000_0000, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("word0_kept", 0, d, 32'hCAFE_F00D);
        doTransfer(0, 0, 32'h8000_0FFC, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("last_word", 0, d, 32'h0BAD_C0DE);
        checkOutput("last_resp", 0, 32'(r), 32'd0);

        // Address-only and data-only writes must not be accepted
        awaddr[0] = 32'h8000_0000; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 8'h0F;
        awvalid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("aw_only_awready", 0, 32'(awready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        awvalid[0] = 1'b0;
        wvalid[0]  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("w_only_wready", 0, 32'(wready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        wvalid[0] = 1'b0;
        doTransfer(0, 0, 32'h8000_0000, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("half_write_ignored", 0, d, 32'hCAFE_F00D);

        // Read and write together: read first, write after the read handshake
        araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1;
        awaddr[0] = 32'h8000_0004; wdata[0] = 32'h55AA_55AA; wstrb[0] = 8'h0F;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        checkOutput("both_arready", 0, 32'(arready[0]), 32'd1);
        checkOutput("both_awready", 0, 32'(awready[0]), 32'd0);
        @(posedge clk);
        #1;
        arvalid[0] = 1'b0;
        awaitResponse(0, 0, 0, d, r, l);
        checkOutput("both_rd_data", 0, d, 32'hCAFE_F00D);
        applyStimulus(0, 1, 32'h8000_0004, 32'h55AA_55AA, 8'h0F);
        awaitResponse(0, 1, 0, d, r, l);
        checkOutput("both_wr_resp", 0, 32'(r), 32'd0);
        doTransfer(0, 0, 32'h8000_0004, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("both_wr_data", 0, d, 32'h55AA_55AA);

        // Response held for five cycles with rready low
        doTransfer(0, 0, 32'h8000_0010, 32'h0, 8'h0, 5, d, r, l);
        checkOutput("hold_data", 0, d, 32'hDEAD_AAEF);

        // Latency-4 instance: normal transfer, then reset mid-write
        doTransfer(1, 1, 32'h8000_0020, 32'h1122_3344, 8'h0F, 0, d, r, l);
`ifndef DMEM_RAND_DELAY_EN
        checkOutput("l4_wr_lat", 1, 32'(l), 32'd4);
`endif
        doTransfer(1, 0, 32'h8000_0020, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("l4_rd_data", 1, d, 32'h1122_3344);
`ifndef DMEM_RAND_DELAY_EN
        checkOutput("l4_rd_lat", 1, 32'(l), 32'd4);
`endif
        applyStimulus(1, 1, 32'h8000_0020, 32'hFFFF_FFFF, 8'h0F);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_bvalid", 1, 32'(bvalid[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        doTransfer(1, 0, 32'h8000_0020, 32'h0, 8'h0, 0, d, r, l);
        checkOutput("abort_word_kept", 1, d, 32'h1122_3344);

        repeat (3) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
